// File: rtl/toy_phy_reg_freelist_if.sv
// Allocation/release bundle between rename and the physical-register free list.
// Handshake: a lane is served only in a cycle where v_alloc_req[i] and v_alloc_gnt[i] are both high;
// v_alloc_phy_id[i] is the ID handed over in that cycle.
interface toy_phy_reg_freelist_if #(
  parameter int PHY_REG_NUM      = 128,
  parameter int PHY_REG_ID_WIDTH = 7,
  parameter int ALLOC_CHANNEL    = 4
);
  logic [PHY_REG_NUM-1:0]                         v_phy_release;
  logic [PHY_REG_NUM-1:0]                         v_phy_back_ref;
  logic                                           flush;
  logic [ALLOC_CHANNEL-1:0]                       v_alloc_req;
  logic [ALLOC_CHANNEL-1:0]                       v_alloc_gnt;
  logic [ALLOC_CHANNEL-1:0][PHY_REG_ID_WIDTH-1:0] v_alloc_phy_id;
  logic [PHY_REG_ID_WIDTH:0]                      free_cnt;

  modport master (
    output v_phy_release, v_phy_back_ref, flush, v_alloc_req,
    input  v_alloc_gnt, v_alloc_phy_id, free_cnt
  );

  modport slave (
    input  v_phy_release, v_phy_back_ref, flush, v_alloc_req,
    output v_alloc_gnt, v_alloc_phy_id, free_cnt
  );
endinterface

// File: rtl/toy_phy_reg_freelist.sv
// Physical-register free list: free bitmask plus one pre-picked staging slot per rename lane,
// refilled from the lowest free IDs and rebuilt from the back-reference map on flush.
module toy_phy_reg_freelist #(
  parameter int PHY_REG_NUM      = 128,
  parameter int PHY_REG_ID_WIDTH = 7,
  parameter int ARCH_ENTRY_NUM   = 32,
  parameter int ALLOC_CHANNEL    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  toy_phy_reg_freelist_if.slave  bus
);
  localparam int N = PHY_REG_NUM;
  localparam int W = PHY_REG_ID_WIDTH;
  localparam int C = ALLOC_CHANNEL;
  localparam logic [N-1:0] RESET_FREE = {N{1'b1}} << ARCH_ENTRY_NUM;
  localparam logic [W:0]   RESET_CNT  = (W+1)'(PHY_REG_NUM - ARCH_ENTRY_NUM);

  logic [N-1:0]          free_q, free_d;
  logic [C-1:0]          slot_vld_q, slot_vld_d;
  logic [C-1:0][W-1:0]   slot_id_q, slot_id_d;
  logic [W:0]            free_cnt_q, free_cnt_d;
  logic [C-1:0]          gnt;
  logic [C-1:0]          refill;
  logic                  grant_ok;

  // All-or-nothing: any requesting lane without a staged ID stalls the whole group.
  assign grant_ok = ~rst & ~bus.flush & ((bus.v_alloc_req & ~slot_vld_q) == '0);
  assign gnt      = grant_ok ? bus.v_alloc_req : '0;
  assign refill   = ~slot_vld_q | gnt;

  assign bus.v_alloc_gnt    = gnt;
  assign bus.v_alloc_phy_id = slot_id_q;
  assign bus.free_cnt       = free_cnt_q;

  always_comb begin
    logic [N-1:0] pool;
    logic         found;
    logic [W-1:0] pick;
    logic [W:0]   cnt;
    pool       = free_q | bus.v_phy_release;
    found      = 1'b0;
    pick       = '0;
    cnt        = '0;
    slot_vld_d = slot_vld_q;
    slot_id_d  = slot_id_q;
    // Slots in ascending order each take the lowest ID still left in the pool.
    for (int i = 0; i < C; i++) begin
      if (refill[i]) begin
        found = 1'b0;
        pick  = '0;
        for (int j = 0; j < N; j++) begin
          if (!found && pool[j]) begin
            found = 1'b1;
            pick  = W'(j);
          end
        end
        slot_vld_d[i] = found;
        if (found) begin
          slot_id_d[i] = pick;
          pool[pick]   = 1'b0;
        end
      end
    end
    free_d = pool;
    if (bus.flush) begin
      free_d     = ~bus.v_phy_back_ref;
      slot_vld_d = '0;
    end
    for (int j = 0; j < N; j++) cnt = cnt + (W+1)'(free_d[j]);
    for (int i = 0; i < C; i++) cnt = cnt + (W+1)'(slot_vld_d[i]);
    free_cnt_d = cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      free_q     <= RESET_FREE;
      slot_vld_q <= '0;
      slot_id_q  <= '0;
      free_cnt_q <= RESET_CNT;
    end else begin
      free_q     <= free_d;
      slot_vld_q <= slot_vld_d;
      slot_id_q  <= slot_id_d;
      free_cnt_q <= free_cnt_d;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    logic [N-1:0] staged;
    staged = '0;
    for (int i = 0; i < C; i++) if (slot_vld_q[i]) staged[slot_id_q[i]] = 1'b1;
    a_req_in_reset: assert (!(rst && (bus.v_alloc_req != '0)));
    if (!rst) begin
      a_double_release: assert ((bus.v_phy_release & (free_q | staged)) == '0);
    end
  end
`endif
endmodule

// File: tb/tb_toy_phy_reg_freelist.sv
// Randomized check of toy_phy_reg_freelist against a set/queue reference model, after directed scenarios.
module tb_toy_phy_reg_freelist;
  localparam int N = 128;
  localparam int W = 7;
  localparam int A = 32;
  localparam int C = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  toy_phy_reg_freelist_if #(.PHY_REG_NUM(N), .PHY_REG_ID_WIDTH(W), .ALLOC_CHANNEL(C)) bus();

  toy_phy_reg_freelist #(
    .PHY_REG_NUM(N), .PHY_REG_ID_WIDTH(W), .ARCH_ENTRY_NUM(A), .ALLOC_CHANNEL(C)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: free set, staged slots, and IDs held by the rest of the machine.
  bit m_free[N];
  bit m_used[N];
  bit m_vld[C];
  int m_id[C];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int j = 0; j < N; j++) begin
      m_free[j] = (j >= A);
      m_used[j] = (j < A);
    end
    for (int i = 0; i < C; i++) begin
      m_vld[i] = 1'b0;
      m_id[i]  = 0;
    end
  endfunction

  function automatic int model_cnt();
    int n = 0;
    for (int j = 0; j < N; j++) n += m_free[j];
    for (int i = 0; i < C; i++) n += m_vld[i];
    return n;
  endfunction

  // Called just after a falling edge; drives one cycle, checks, advances the model, waits one cycle.
  task automatic step(input logic [C-1:0] req, input logic [N-1:0] rel, input logic [N-1:0] bref,
                      input logic fl, input bit use_g, input logic [C-1:0] want_g);
    logic [C-1:0] eg;
    bit           ok;
    int           pool[$];
    bus.v_alloc_req    = req;
    bus.v_phy_release  = rel;
    bus.v_phy_back_ref = bref;
    bus.flush          = fl;
    #1;
    ok = !fl;
    for (int i = 0; i < C; i++) if (req[i] && !m_vld[i]) ok = 0;
    eg = ok ? req : '0;
    check_val("gnt", 32'(bus.v_alloc_gnt), 32'(eg));
    if (use_g) check_val("gnt_plan", 32'(bus.v_alloc_gnt), 32'(want_g));
    for (int i = 0; i < C; i++)
      if (m_vld[i]) check_val($sformatf("id%0d", i), 32'(bus.v_alloc_phy_id[i]), m_id[i]);
    check_val("free_cnt", 32'(bus.free_cnt), model_cnt());
    if (fl) begin
      for (int j = 0; j < N; j++) begin
        m_free[j] = !bref[j];
        m_used[j] = bref[j];
      end
      for (int i = 0; i < C; i++) m_vld[i] = 1'b0;
    end else begin
      for (int i = 0; i < C; i++) if (eg[i]) m_used[m_id[i]] = 1'b1;
      for (int j = 0; j < N; j++) if (rel[j]) m_used[j] = 1'b0;
      for (int j = 0; j < N; j++) if (m_free[j] || rel[j]) pool.push_back(j);
      for (int i = 0; i < C; i++) begin
        if (!m_vld[i] || eg[i]) begin
          if (pool.size() > 0) begin
            m_id[i]  = pool.pop_front();
            m_vld[i] = 1'b1;
          end else begin
            m_vld[i] = 1'b0;
          end
        end
      end
      for (int j = 0; j < N; j++) m_free[j] = 1'b0;
      foreach (pool[k]) m_free[pool[k]] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic pick_release(input int k, output logic [N-1:0] rel);
    int u[$];
    int idx;
    rel = '0;
    for (int j = 0; j < N; j++) if (m_used[j]) u.push_back(j);
    repeat (k) begin
      if (u.size() > 0) begin
        idx = $urandom_range(0, u.size() - 1);
        rel[u[idx]] = 1'b1;
        u.delete(idx);
      end
    end
  endtask

  function automatic bit model_empty();
    for (int j = 0; j < N; j++) if (m_free[j]) return 1'b0;
    for (int i = 0; i < C; i++) if (m_vld[i]) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    logic [N-1:0] rel;
    logic [N-1:0] bref;
    logic [N-1:0] arch_ref;
    logic [C-1:0] req;
    logic         fl;
    int           k;
    rst = 1'b1;
    bus.v_alloc_req    = '0;
    bus.v_phy_release  = '0;
    bus.v_phy_back_ref = '0;
    bus.flush          = 1'b0;
    arch_ref = '0;
    for (int j = 0; j < A; j++) arch_ref[j] = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_val("rst_gnt", 32'(bus.v_alloc_gnt), 0);
    check_val("rst_free_cnt", 32'(bus.free_cnt), 96);

    // Scenario 1: first refill after reset.
    rst = 1'b0;
    step('0, '0, '0, 1'b0, 1'b1, 4'b0000);
    for (int i = 0; i < C; i++) check_val("s1_id", 32'(bus.v_alloc_phy_id[i]), 32 + i);
    check_val("s1_free_cnt", 32'(bus.free_cnt), 96);

    // Scenario 2: full-width grant.
    step(4'b1111, '0, '0, 1'b0, 1'b1, 4'b1111);
    for (int i = 0; i < C; i++) check_val("s2_id", 32'(bus.v_alloc_phy_id[i]), 36 + i);
    check_val("s2_free_cnt", 32'(bus.free_cnt), 92);

    // Scenario 3: sparse lanes.
    step(4'b0101, '0, '0, 1'b0, 1'b1, 4'b0101);
    check_val("s3_id0", 32'(bus.v_alloc_phy_id[0]), 40);
    check_val("s3_id1", 32'(bus.v_alloc_phy_id[1]), 37);
    check_val("s3_id2", 32'(bus.v_alloc_phy_id[2]), 41);
    check_val("s3_id3", 32'(bus.v_alloc_phy_id[3]), 39);

    // Scenario 6: asynchronous reset in the middle of a granting cycle.
    bus.v_alloc_req = 4'b1111;
    #1;
    check_val("s6_gnt_before", 32'(bus.v_alloc_gnt), 32'hF);
    #2;
    rst = 1'b1;
    #1;
    check_val("s6_gnt_in_rst", 32'(bus.v_alloc_gnt), 0);
    check_val("s6_free_cnt", 32'(bus.free_cnt), 96);
    bus.v_alloc_req = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step('0, '0, '0, 1'b0, 1'b1, 4'b0000);
    for (int i = 0; i < C; i++) check_val("s6_id", 32'(bus.v_alloc_phy_id[i]), 32 + i);
    check_val("s6_free_cnt_after", 32'(bus.free_cnt), 96);

    // Scenario 5: flush mid-stream rebuilds from the back-reference map.
    step(4'b1111, '0, '0, 1'b0, 1'b1, 4'b1111);
    step(4'b1111, '0, arch_ref, 1'b1, 1'b1, 4'b0000);
    check_val("s5_free_cnt", 32'(bus.free_cnt), 96);
    step('0, '0, '0, 1'b0, 1'b1, 4'b0000);
    for (int i = 0; i < C; i++) check_val("s5_id", 32'(bus.v_alloc_phy_id[i]), 32 + i);
    check_val("s5_free_cnt_after", 32'(bus.free_cnt), 96);

    // Scenario 4: drain to empty, then a single release refills lane 0.
    for (int c = 0; c < 40 && !model_empty(); c++) step(4'b1111, '0, '0, 1'b0, 1'b0, '0);
    check_val("s4_drained_cnt", 32'(bus.free_cnt), 0);
    step(4'b0001, '0, '0, 1'b0, 1'b1, 4'b0000);
    rel = '0;
    rel[5] = 1'b1;
    step(4'b0001, rel, '0, 1'b0, 1'b1, 4'b0000);
    check_val("s4_id0", 32'(bus.v_alloc_phy_id[0]), 5);
    step(4'b0001, '0, '0, 1'b0, 1'b1, 4'b0001);

    // Random traffic with alternating release pressure and occasional flushes.
    for (int c = 0; c < 1500; c++) begin
      req  = C'($urandom_range(0, 15));
      fl   = ($urandom_range(0, 59) == 0);
      rel  = '0;
      bref = '0;
      if (fl) begin
        for (int j = 0; j < N; j++) if (m_used[j] && $urandom_range(0, 7) != 0) bref[j] = 1'b1;
      end else begin
        k = $urandom_range(0, ((c % 300) < 150) ? 3 : 1);
        pick_release(k, rel);
      end
      step(req, rel, bref, fl, 1'b0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
